// File: rtl/instruction_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_if
// Purpose  : Instruction-memory read handshake between fetch unit and memory.
// Revision : 1.0 - initial release
// ============================================================================
interface instruction_fetch_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Purpose  : PC owner and instruction register for a single-cycle MIPS core.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    instruction_fetch_if.master imem,
    output logic [31:0]         Instruction,
    output logic [5:0]          Opcode,
    output logic [ADDR_W-1:0]   PC,
    output logic [ADDR_W-1:0]   PCplus4,
    output logic                instr_valid,
    input  logic                retire,
    input  logic                Branch,
    input  logic                Zero,
    output logic [31:0]         retired_count
);

    localparam int c_EXT_W = ADDR_W - 18;

    typedef enum logic [1:0] {
        c_IDLE  = 2'd0,
        c_FETCH = 2'd1,
        c_EXEC  = 2'd2
    } state_t;

    state_t            r_state_q;
    state_t            w_state_d;
    logic [ADDR_W-1:0] r_pc_q;
    logic [ADDR_W-1:0] w_pc_d;
    logic [31:0]       r_instr_q;
    logic [31:0]       w_instr_d;
    logic [31:0]       r_count_q;
    logic [31:0]       w_count_d;
    logic              r_req_q;
    logic              w_req_d;
    logic              r_valid_q;
    logic              w_valid_d;

    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_branch_off;
    logic [ADDR_W-1:0] w_branch_target;

    assign w_pc_plus4      = r_pc_q + ADDR_W'(4);
    // beq immediate is a signed word offset relative to the following instruction
    assign w_branch_off    = {{c_EXT_W{r_instr_q[15]}}, r_instr_q[15:0], 2'b00};
    assign w_branch_target = w_pc_plus4 + w_branch_off;

    always_comb begin
        w_state_d = r_state_q;
        w_pc_d    = r_pc_q;
        w_instr_d = r_instr_q;
        w_count_d = r_count_q;
        case (r_state_q)
            c_IDLE: begin
                w_state_d = c_FETCH;
            end
            c_FETCH: begin
                if (imem.imem_ready) begin
                    w_instr_d = imem.imem_rdata;
                    w_state_d = c_EXEC;
                end
            end
            c_EXEC: begin
                if (retire) begin
                    w_pc_d    = (Branch & Zero) ? w_branch_target : w_pc_plus4;
                    w_count_d = r_count_q + 32'd1;
                    w_state_d = c_FETCH;
                end
            end
            default: begin
                w_state_d = c_IDLE;
            end
        endcase
    end

    // Handshake outputs are registered from the next state so they align with it
    assign w_req_d   = (w_state_d == c_FETCH);
    assign w_valid_d = (w_state_d == c_EXEC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q <= c_IDLE;
            r_pc_q    <= RESET_PC;
            r_instr_q <= 32'd0;
            r_count_q <= 32'd0;
            r_req_q   <= 1'b0;
            r_valid_q <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_pc_q    <= w_pc_d;
            r_instr_q <= w_instr_d;
            r_count_q <= w_count_d;
            r_req_q   <= w_req_d;
            r_valid_q <= w_valid_d;
        end
    end

    assign imem.imem_req  = r_req_q;
    assign imem.imem_addr = r_pc_q;
    assign Instruction    = r_instr_q;
    assign Opcode         = r_instr_q[31:26];
    assign PC             = r_pc_q;
    assign PCplus4        = w_pc_plus4;
    assign instr_valid    = r_valid_q;
    assign retired_count  = r_count_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch
// Purpose  : Self-checking bench for instruction_fetch against a PC/count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0100;

    logic        clk;
    logic        reset;
    logic        retire;
    logic        Branch;
    logic        Zero;
    logic [31:0] Instruction;
    logic [5:0]  Opcode;
    logic [31:0] PC;
    logic [31:0] PCplus4;
    logic        instr_valid;
    logic [31:0] retired_count;

    int errors = 0;
    int checks = 0;

    logic [31:0] model_pc;
    logic [31:0] model_cnt;

    instruction_fetch_if #(.ADDR_W(32)) imem_bus ();

    instruction_fetch #(
        .ADDR_W   (32),
        .RESET_PC (c_RESET_PC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem          (imem_bus.master),
        .Instruction   (Instruction),
        .Opcode        (Opcode),
        .PC            (PC),
        .PCplus4       (PCplus4),
        .instr_valid   (instr_valid),
        .retire        (retire),
        .Branch        (Branch),
        .Zero          (Zero),
        .retired_count (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] branch_word(input logic [31:0] from, input logic [31:0] to);
        logic [31:0] d;
        d = to - from - 32'd4;
        return {16'h1000, d[17:2]};
    endfunction

    // Fetch one word with a number of wait states; entered and left one tick after an edge.
    task automatic fetch_phase(input int waits, input logic [31:0] word, input bit pulse_retire);
        if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== model_pc) begin
            errors++;
            $display("FAIL fetch_entry: req=%0b addr=%h, required req=1 addr=%h",
                     imem_bus.imem_req, imem_bus.imem_addr, model_pc);
        end
        checks++;
        for (int i = 0; i < waits; i++) begin
            imem_bus.imem_ready = 1'b0;
            imem_bus.imem_rdata = $urandom;
            retire = pulse_retire ? 1'($urandom_range(0, 1)) : 1'b0;
            Branch = 1'($urandom_range(0, 1));
            Zero   = 1'($urandom_range(0, 1));
            step();
            if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== model_pc || PC !== model_pc ||
                retired_count !== model_cnt || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL fetch_wait: req=%0b addr=%h pc=%h cnt=%0d valid=%0b, required 1 %h %h %0d 0",
                         imem_bus.imem_req, imem_bus.imem_addr, PC, retired_count, instr_valid,
                         model_pc, model_pc, model_cnt);
            end
            checks++;
        end
        imem_bus.imem_ready = 1'b1;
        imem_bus.imem_rdata = word;
        retire = pulse_retire ? 1'b1 : 1'b0;
        step();
        retire = 1'b0;
        if (instr_valid !== 1'b1 || Instruction !== word || Opcode !== word[31:26] ||
            imem_bus.imem_req !== 1'b0 || PC !== model_pc || retired_count !== model_cnt) begin
            errors++;
            $display("FAIL fetch_load: valid=%0b instr=%h op=%b req=%0b pc=%h cnt=%0d, required 1 %h %b 0 %h %0d",
                     instr_valid, Instruction, Opcode, imem_bus.imem_req, PC, retired_count,
                     word, word[31:26], model_pc, model_cnt);
        end
        checks++;
    endtask

    // Hold the instruction for some cycles, then retire it with the given Branch/Zero.
    task automatic exec_phase(input int hold, input logic br, input logic z);
        logic [31:0] word;
        word = Instruction;
        for (int i = 0; i < hold; i++) begin
            retire = 1'b0;
            imem_bus.imem_ready = 1'($urandom_range(0, 1));
            imem_bus.imem_rdata = $urandom;
            Branch = 1'($urandom_range(0, 1));
            Zero   = 1'($urandom_range(0, 1));
            step();
            if (instr_valid !== 1'b1 || Instruction !== word || PC !== model_pc ||
                retired_count !== model_cnt || imem_bus.imem_req !== 1'b0) begin
                errors++;
                $display("FAIL exec_hold: valid=%0b instr=%h pc=%h cnt=%0d req=%0b, required 1 %h %h %0d 0",
                         instr_valid, Instruction, PC, retired_count, imem_bus.imem_req,
                         word, model_pc, model_cnt);
            end
            checks++;
        end
        if (PCplus4 !== model_pc + 32'd4) begin
            errors++;
            $display("FAIL pcplus4: got %h, required %h", PCplus4, model_pc + 32'd4);
        end
        checks++;
        retire = 1'b1;
        Branch = br;
        Zero   = z;
        step();
        retire = 1'b0;
        Branch = 1'b0;
        Zero   = 1'b0;
        if (br && z) model_pc = model_pc + 32'd4 + 32'(int'($signed(word[15:0])) * 4);
        else         model_pc = model_pc + 32'd4;
        model_cnt = model_cnt + 32'd1;
        if (PC !== model_pc || retired_count !== model_cnt || instr_valid !== 1'b0 ||
            imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== model_pc) begin
            errors++;
            $display("FAIL retire: pc=%h cnt=%0d valid=%0b req=%0b addr=%h, required %h %0d 0 1 %h",
                     PC, retired_count, instr_valid, imem_bus.imem_req, imem_bus.imem_addr,
                     model_pc, model_cnt, model_pc);
        end
        checks++;
    endtask

    task automatic release_reset();
        reset = 1'b0;
        model_pc  = c_RESET_PC;
        model_cnt = 32'd0;
        if (imem_bus.imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_release: req=%0b valid=%0b, required 0 0",
                     imem_bus.imem_req, instr_valid);
        end
        checks++;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        retire = 1'b0;
        Branch = 1'b0;
        Zero   = 1'b0;
        imem_bus.imem_ready = 1'b1;
        imem_bus.imem_rdata = 32'h8C08_0004;
        repeat (3) step();
        if (PC !== c_RESET_PC || Instruction !== 32'd0 || Opcode !== 6'd0 || retired_count !== 32'd0 ||
            imem_bus.imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: pc=%h instr=%h op=%b cnt=%0d req=%0b valid=%0b, required %h 0 0 0 0 0",
                     PC, Instruction, Opcode, retired_count, imem_bus.imem_req, instr_valid, c_RESET_PC);
        end
        checks++;
        release_reset();
    endtask

    task automatic test_first_fetch();
        fetch_phase(0, 32'h8C08_0004, 1'b0);
        if (Opcode !== 6'b100011) begin
            errors++;
            $display("FAIL lw_opcode: got %b, required 100011", Opcode);
        end
        checks++;
        exec_phase(0, 1'b0, 1'b1);
        if (PC !== 32'h104 || retired_count !== 32'd1) begin
            errors++;
            $display("FAIL lw_retire: pc=%h cnt=%0d, required 104 1", PC, retired_count);
        end
        checks++;
    endtask

    task automatic test_branch();
        fetch_phase(1, branch_word(model_pc, 32'h200), 1'b0);
        exec_phase(2, 1'b1, 1'b1);
        fetch_phase(0, 32'h1000_FFFE, 1'b0);
        exec_phase(0, 1'b1, 1'b1);
        if (PC !== 32'h1FC) begin
            errors++;
            $display("FAIL beq_taken: pc=%h, required 1fc", PC);
        end
        checks++;
        fetch_phase(0, branch_word(model_pc, 32'h200), 1'b0);
        exec_phase(0, 1'b1, 1'b1);
        fetch_phase(0, 32'h1000_FFFE, 1'b0);
        exec_phase(1, 1'b1, 1'b0);
        if (PC !== 32'h204) begin
            errors++;
            $display("FAIL beq_not_taken: pc=%h, required 204", PC);
        end
        checks++;
        fetch_phase(0, 32'h1000_0010, 1'b0);
        exec_phase(0, 1'b0, 1'b1);
    endtask

    task automatic test_wait_states();
        fetch_phase(5, 32'h0123_4567, 1'b1);
        exec_phase(3, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_exec();
        fetch_phase(0, branch_word(model_pc, 32'h40), 1'b0);
        exec_phase(0, 1'b1, 1'b1);
        fetch_phase(2, 32'hABCD_1234, 1'b0);
        if (PC !== 32'h40) begin
            errors++;
            $display("FAIL reach_0x40: pc=%h, required 40", PC);
        end
        checks++;
        reset = 1'b1;
        #1;
        if (instr_valid !== 1'b0 || PC !== c_RESET_PC || Instruction !== 32'd0 ||
            retired_count !== 32'd0 || imem_bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: valid=%0b pc=%h instr=%h cnt=%0d req=%0b, required 0 %h 0 0 0",
                     instr_valid, PC, Instruction, retired_count, imem_bus.imem_req, c_RESET_PC);
        end
        checks++;
        step();
        step();
        release_reset();
    endtask

    task automatic test_wrap();
        fetch_phase(0, branch_word(model_pc, 32'hFFFF_FFFC), 1'b0);
        exec_phase(0, 1'b1, 1'b1);
        fetch_phase(1, 32'h0000_0020, 1'b0);
        exec_phase(0, 1'b0, 1'b0);
        if (PC !== 32'd0 || imem_bus.imem_addr !== 32'd0) begin
            errors++;
            $display("FAIL pc_wrap: pc=%h addr=%h, required 0 0", PC, imem_bus.imem_addr);
        end
        checks++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            fetch_phase($urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)));
            exec_phase($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (PC[1:0] !== 2'b00) begin
                errors++;
                $display("FAIL pc_aligned: pc=%h, required low bits 00", PC);
            end
            checks++;
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 8; n++) begin
            fetch_phase(0, {6'b000100, 10'd0, 16'($urandom)}, 1'b0);
            exec_phase(0, 1'b1, 1'(n % 2));
        end
    endtask

    initial begin
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rdata = 32'd0;
        model_pc  = c_RESET_PC;
        model_cnt = 32'd0;
        test_reset();
        test_first_fetch();
        test_branch();
        test_wait_states();
        test_back_to_back();
        test_reset_mid_exec();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Upstream neighbour of the main decoder in the single-cycle MIPS datapath.
- Owns the PC and requests instructions from instruction memory over a ready handshake.
- Holds the fetched word steady in an instruction register while the datapath executes it.
- Drives Opcode (Instruction[31:26]) to the decoder; on retire, selects the next PC as sequential or as the beq target.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- ADDR_W, 32, PC/address width; arithmetic is modulo 2^ADDR_W.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  instruction-memory read request.
- imem_addr  out  ADDR_W  read address; equals PC while imem_req=1.
- imem_rdata  in  32  instruction word; valid when imem_ready=1.
- imem_ready  in  1  memory has data; one-cycle strobe or level, sampled only in FETCH.
- Instruction  out  32  instruction register.
- Opcode  out  6  Instruction[31:26], to the decoder.
- PC  out  ADDR_W  address of the instruction currently held.
- PCplus4  out  ADDR_W  PC+4, combinational.
- instr_valid  out  1  Instruction holds a fetched word under execution.
- retire  in  1  datapath completes the held instruction this cycle.
- Branch  in  1  decoder branch signal.
- Zero  in  1  ALU zero flag.
- retired_count  out  32  number of retired instructions.

Behaviour:
- Reset (async, takes effect immediately):
  - state=IDLE, PC=RESET_PC, Instruction=0, retired_count=0.
  - imem_req=0, instr_valid=0; Opcode=0 by construction.
- FSM, 3 states: IDLE, FETCH, EXEC.
- IDLE:
  - imem_req=0, instr_valid=0.
  - Unconditional transition to FETCH on the next edge; first request appears 1 cycle after reset release.
- FETCH:
  - imem_req=1, imem_addr=PC, instr_valid=0.
  - Stays in FETCH while imem_ready=0; any wait-state count allowed.
  - On an edge with imem_ready=1: Instruction<=imem_rdata, go to EXEC.
  - retire is ignored in FETCH.
- EXEC:
  - imem_req=0, instr_valid=1; Instruction and PC held constant.
  - imem_ready is ignored in EXEC.
  - Stays in EXEC while retire=0.
  - On an edge with retire=1: go to FETCH and update PC and retired_count.
    - If Branch&Zero=1: PC <= PCplus4 + (signext(Instruction[15:0])<<2).
    - Otherwise: PC <= PCplus4.
    - retired_count <= retired_count+1.
- Latency: minimum 2 cycles per instruction (FETCH with immediate ready, then EXEC with immediate retire).
- Arithmetic:
  - All PC arithmetic is modulo 2^ADDR_W; wrap-around is silent. Example: PC=32'hFFFF_FFFC retires non-branch -> PC=0.
  - Negative offsets wrap correctly.
  - PC[1:0] is always 00.
  - retired_count wraps from 32'hFFFF_FFFF to 0.
- Branch and Zero are sampled only on the retire edge; their values at any other time have no effect.
- Reset asserted mid-FETCH or mid-EXEC aborts immediately; no partial Instruction or PC update occurs.

Test Plan:
- Reset with RESET_PC=0x100, release, imem_ready tied 1, rdata=0x8C080004 (lw) -> imem_req rises 1 cycle after release with imem_addr=0x100; next cycle Instruction=0x8C080004, Opcode=6'b100011, instr_valid=1.
- Retire lw at PC=0x100, Branch=0 -> next cycle PC=0x104, imem_addr=0x104, retired_count=1.
- beq 0x1000FFFE at PC=0x200, Branch=1, Zero=1, retire -> PC=0x200+4-8=0x1FC; repeat with Zero=0 -> PC=0x204.
- imem_ready held 0 for 5 cycles in FETCH, with retire pulsed during the wait -> imem_req stays 1, addr stable, PC and retired_count unchanged, Instruction loaded only on ready.
- Reset asserted in EXEC with PC=0x40 -> same cycle: instr_valid=0, PC=RESET_PC, Instruction=0, retired_count=0.
- PC=0xFFFFFFFC, non-branch retire -> PC=0x00000000, fetch from address 0.
